// File: rtl/multi_btn_ctl_if.sv
// multi_btn_ctl_if: button pins, repeat enables and debounced event outputs
//   pb_i            raw button pins, 1 = pressed
//   repeat_en_i     per-channel auto-repeat enable
//   pb_level_o      debounced level
//   press_pulse_o   1-cycle press event
//   release_pulse_o 1-cycle release event
//   long_pulse_o    1-cycle long-press event
//   repeat_pulse_o  1-cycle auto-repeat event
interface multi_btn_ctl_if #(parameter int N_BTN = 5);
   logic [N_BTN-1:0] pb_i;
   logic [N_BTN-1:0] repeat_en_i;
   logic [N_BTN-1:0] pb_level_o;
   logic [N_BTN-1:0] press_pulse_o;
   logic [N_BTN-1:0] release_pulse_o;
   logic [N_BTN-1:0] long_pulse_o;
   logic [N_BTN-1:0] repeat_pulse_o;
   modport master (output pb_i, repeat_en_i,
                   input pb_level_o, press_pulse_o, release_pulse_o, long_pulse_o, repeat_pulse_o);
   modport slave (input pb_i, repeat_en_i,
                  output pb_level_o, press_pulse_o, release_pulse_o, long_pulse_o, repeat_pulse_o);
endinterface

// File: rtl/multi_btn_ctl.sv
// multi_btn_ctl: per-channel sync, debounce and press/release/long/repeat pulse generation
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  multi_btn_ctl_if slave: pins/enables in, level and event pulses out
module multi_btn_ctl #(
   parameter int N_BTN        = 5,
   parameter int DB_TICKS     = 1_000_000,
   parameter int HOLD_TICKS   = 50_000_000,
   parameter int REPEAT_TICKS = 10_000_000,
   parameter int CNT_W        = 26
) (
   input logic             clk,
   input logic             rst,
   multi_btn_ctl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
   logic [N_BTN-1:0] s1_q, s2_q;
   logic [N_BTN-1:0] lvl_v, prs_v, rel_v, lng_v, rpt_v;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= bus.pb_i;
         s2_q <= s1_q;
      end
   end
   for (genvar c = 0; c < N_BTN; c++) begin : g_ch
      state_t           st_q, st_d;
      logic [CNT_W-1:0] db_q, db_d, hold_q, hold_d;
      logic             lvl_q, lvl_d, prs_q, prs_d, rel_q, rel_d, lng_q, lng_d, rpt_q, rpt_d;
      logic             db_done;
      assign db_done = db_q == CNT_W'(DB_TICKS - 1);
      // Events key off lvl_d so each pulse lands in the same cycle as its level edge.
      always_comb begin
         db_d   = (s2_q[c] != lvl_q && !db_done) ? db_q + CNT_W'(1) : '0;
         lvl_d  = (s2_q[c] != lvl_q && db_done) ? s2_q[c] : lvl_q;
         st_d   = st_q;
         hold_d = hold_q + CNT_W'(1);
         prs_d  = 1'b0;
         rel_d  = 1'b0;
         lng_d  = 1'b0;
         rpt_d  = 1'b0;
         case (st_q)
            IDLE: begin
               hold_d = '0;
               if (lvl_d && !lvl_q) begin
                  prs_d = 1'b1;
                  st_d  = PRESSED;
               end
            end
            PRESSED: begin
               if (!lvl_d) begin
                  rel_d = 1'b1;
                  st_d  = IDLE;
               end else if (hold_q == CNT_W'(HOLD_TICKS - 1)) begin
                  lng_d  = 1'b1;
                  hold_d = '0;
                  st_d   = HELD;
               end
            end
            HELD: begin
               if (!lvl_d) begin
                  rel_d = 1'b1;
                  st_d  = IDLE;
               end else if (hold_q == CNT_W'(REPEAT_TICKS - 1)) begin
                  rpt_d  = bus.repeat_en_i[c];
                  hold_d = '0;
               end
            end
            default: st_d = IDLE;
         endcase
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            st_q   <= IDLE;
            db_q   <= '0;
            hold_q <= '0;
            lvl_q  <= 1'b0;
            prs_q  <= 1'b0;
            rel_q  <= 1'b0;
            lng_q  <= 1'b0;
            rpt_q  <= 1'b0;
         end else begin
            st_q   <= st_d;
            db_q   <= db_d;
            hold_q <= hold_d;
            lvl_q  <= lvl_d;
            prs_q  <= prs_d;
            rel_q  <= rel_d;
            lng_q  <= lng_d;
            rpt_q  <= rpt_d;
         end
      end
      assign lvl_v[c] = lvl_q;
      assign prs_v[c] = prs_q;
      assign rel_v[c] = rel_q;
      assign lng_v[c] = lng_q;
      assign rpt_v[c] = rpt_q;
   end
   assign bus.pb_level_o      = lvl_v;
   assign bus.press_pulse_o   = prs_v;
   assign bus.release_pulse_o = rel_v;
   assign bus.long_pulse_o    = lng_v;
   assign bus.repeat_pulse_o  = rpt_v;
endmodule
